// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of the combinational barrel_shifter, plus the result
// register that carries shifter output downstream over valid/ready.
module shift_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic [2:0]                 in_amt,
  input  logic [2:0]                 in_op,
  output logic [7:0]                 sh_data_in,
  output logic [2:0]                 sh_shift_amt,
  output logic [2:0]                 sh_op_code,
  input  logic [7:0]                 sh_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [2:0]                 out_op,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_data [DEPTH];
  logic [2:0]    mem_amt  [DEPTH];
  logic [2:0]    mem_op   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic          head_legal;

  assign not_empty  = (count != '0);
  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = not_empty && (!out_valid || out_ready);
  assign head_legal = (sh_op_code <= 3'd4);

  // Head is masked to zero when empty so the shifter sees a quiet input.
  always_comb begin
    sh_data_in   = '0;
    sh_shift_amt = '0;
    sh_op_code   = '0;
    if (not_empty) begin
      sh_data_in   = mem_data[rd_ptr];
      sh_shift_amt = mem_amt[rd_ptr];
      sh_op_code   = mem_op[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_amt[wr_ptr]  <= in_amt;
      mem_op[wr_ptr]   <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      out_err   <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_op    <= sh_op_code;
      out_data  <= head_legal ? sh_data_out : 8'h00;
      out_err   <= !head_legal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Randomized and directed bench for shift_cmd_queue, with a behavioural
// barrel shifter and a queue-based reference model of the whole pipeline.
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_op;
  logic [7:0] sh_data_in;
  logic [2:0] sh_shift_amt;
  logic [2:0] sh_op_code;
  logic [7:0] sh_data_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_op;
  logic       out_err;
  logic [2:0] count;

  shift_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .sh_data_in(sh_data_in), .sh_shift_amt(sh_shift_amt), .sh_op_code(sh_op_code),
    .sh_data_out(sh_data_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .out_err(out_err),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic [2:0] op);
    logic signed [7:0] s;
    logic [7:0] r;
    s = d;
    case (op)
      3'd0: r = d << a;
      3'd1: r = d >> a;
      3'd2: r = s >>> a;
      3'd3: r = (d << a) | (d >> (8 - a));
      3'd4: r = (d >> a) | (d << (8 - a));
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign sh_data_out = ref_shift(sh_data_in, sh_shift_amt, sh_op_code);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [2:0] op;
  } cmd_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] op;
    logic       err;
  } res_t;

  // Reference model state, advanced once per cycle from sampled handshakes.
  cmd_t fq[$];
  logic       m_ov, m_oerr;
  logic [7:0] m_od;
  logic [2:0] m_oop;
  bit   started = 0;
  int   n_acc = 0;
  int   n_del = 0;
  res_t obs[$];
  cmd_t mc;
  bit   m_push, m_pop;

  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(count), 32'(fq.size()));
      check("in_ready", 32'(in_ready), 32'(fq.size() != DEPTH));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_op", 32'(out_op), 32'(m_oop));
      check("out_err", 32'(out_err), 32'(m_oerr));
      if (fq.size() != 0) begin
        check("sh_head", {13'd0, sh_data_in, sh_shift_amt, sh_op_code}, {13'd0, fq[0].d, fq[0].a, fq[0].op});
      end else begin
        check("sh_zero", {13'd0, sh_data_in, sh_shift_amt, sh_op_code}, 32'd0);
      end
    end
    if (rst) begin
      fq.delete();
      m_ov = 0; m_od = '0; m_oop = '0; m_oerr = 0;
      started = 1;
    end else if (started) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
        n_del++;
        obs.push_back('{d: out_data, op: out_op, err: out_err});
      end
      m_push = in_valid && (fq.size() != DEPTH);
      m_pop  = (fq.size() != 0) && (!m_ov || out_ready);
      if (m_pop) begin
        mc = fq.pop_front();
        m_ov  = 1;
        m_oop = mc.op;
        m_oerr = (mc.op > 3'd4);
        m_od  = m_oerr ? 8'h00 : ref_shift(mc.d, mc.a, mc.op);
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (m_push) fq.push_back('{d: in_data, a: in_amt, op: in_op});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] op);
    bit done;
    done = 0;
    in_valid = 1; in_data = d; in_amt = a; in_op = op;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [7:0] d_vec [5] = '{8'b10101010, 8'b11001100, 8'b11110000, 8'b10011001, 8'b01101110};
  logic [2:0] a_vec [5] = '{3'd3, 3'd2, 3'd4, 3'd3, 3'd2};
  logic [7:0] e_vec [5] = '{8'b01010000, 8'b00110011, 8'b11111111, 8'b11001100, 8'b10011011};
  cmd_t sent[$];
  int   accepts;
  int   sent_n;
  logic [7:0] held;
  res_t r;

  initial begin
    rst = 1; in_valid = 1; in_data = 8'hA5; in_amt = 3'd1; in_op = 3'd0; out_ready = 1;
    // 1. reset values with in_valid held high
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sh", {13'd0, sh_data_in, sh_shift_amt, sh_op_code}, 32'd0);
    rst = 0; in_valid = 0;
    tick();

    // 2. one command per legal op, two edges to result
    for (int i = 0; i < 5; i++) begin
      send(d_vec[i], a_vec[i], 3'(i));
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      check("op_result", 32'(out_data), 32'(e_vec[i]));
      check("op_tag", 32'(out_op), 32'(i));
      check("op_err", 32'(out_err), 32'd0);
      drain();
    end

    // 3. backpressure: capacity is DEPTH+1
    out_ready = 0;
    accepts = 0;
    sent.delete();
    obs.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_amt = 3'($urandom); in_op = 3'($urandom_range(0, 4));
      @(negedge clk);
      if (!in_ready) break;
      sent.push_back('{d: in_data, a: in_amt, op: in_op});
      accepts++;
      tick();
    end
    tick();
    in_valid = 0;
    check("bp_accepts", 32'(accepts), 32'(DEPTH + 1));
    check("bp_count", 32'(count), 32'(DEPTH));
    held = out_data;
    repeat (3) tick();
    check("bp_hold", 32'(out_data), 32'(held));
    check("bp_first", 32'(held), 32'(ref_shift(sent[0].d, sent[0].a, sent[0].op)));
    out_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge clk);
      check("bp_consecutive", 32'(out_valid), 32'd1);
      tick();
    end
    drain();
    check("bp_n_results", 32'(obs.size()), 32'(DEPTH + 1));
    for (int i = 0; i < obs.size() && i < sent.size(); i++)
      check("bp_order", 32'(obs[i].d), 32'(ref_shift(sent[i].d, sent[i].a, sent[i].op)));

    // 4. illegal op between two legal ones
    obs.delete();
    send(8'h0F, 3'd4, 3'd0);
    send(8'hFF, 3'd1, 3'd7);
    send(8'h01, 3'd1, 3'd4);
    drain();
    check("ill_n", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      check("ill_a", {23'd0, obs[0].err, obs[0].op, obs[0].d}, {23'd0, 1'b0, 3'd0, 8'hF0});
      check("ill_mid", {23'd0, obs[1].err, obs[1].op, obs[1].d}, {23'd0, 1'b1, 3'd7, 8'h00});
      check("ill_b", {23'd0, obs[2].err, obs[2].op, obs[2].d}, {23'd0, 1'b0, 3'd4, 8'h80});
    end

    // 5. simultaneous push/pop at count=2, then random stream with wrap
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)));
    check("pp_pre_count", 32'(count), 32'd2);
    check("pp_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1; in_data = 8'h3C; in_amt = 3'd5; in_op = 3'd3; out_ready = 1;
    @(negedge clk);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    check("pp_count", 32'(count), 32'd2);
    drain();
    n_acc = 0; n_del = 0;
    sent_n = 0;
    for (int i = 0; i < 300 && sent_n < 12; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_amt = 3'($urandom); in_op = 3'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      if (in_ready) sent_n++;
      tick();
    end
    in_valid = 0;
    check("stream_sent", 32'(sent_n), 32'd12);
    drain();
    check("stream_no_loss", 32'(n_del), 32'(n_acc));
    check("stream_acc", 32'(n_acc), 32'd12);

    // 6. reset with entries queued and a pending result
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)));
    check("mr_pre_count", 32'(count), 32'd3);
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    rst = 1; in_valid = 1;
    tick();
    rst = 0; in_valid = 0;
    check("mr_count", 32'(count), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    out_ready = 1;
    send(8'b10000001, 3'd1, 3'd2);
    check("mr_lat1", 32'(out_valid), 32'd0);
    tick();
    check("mr_lat2", 32'(out_valid), 32'd1);
    check("mr_result", 32'(out_data), 32'(8'b11000000));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_cmd_queue.md
# shift_cmd_queue

Command front-end for `barrel_shifter`. It buffers shift commands `{data, amount, op_code}` from an upstream valid/ready source in a DEPTH-entry FIFO and presents the head entry to the combinational shifter. It captures the shifter result into an output register and hands it downstream over valid/ready. It sits directly upstream of the shifter and also owns the result register, so the shifter stays purely combinational.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream command valid.
- `in_ready` out 1: queue can accept; equals `count != DEPTH`.
- `in_data` in 8: operand.
- `in_amt` in 3: shift amount 0–7.
- `in_op` in 3: op code. 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101–111 illegal.
- `sh_data_in` out 8: to shifter `data_in`.
- `sh_shift_amt` out 3: to shifter `shift_amt`.
- `sh_op_code` out 3: to shifter `op_code`.
- `sh_data_out` in 8: from shifter `data_out`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 8: result.
- `out_op` out 3: op code of the result, for tagging.
- `out_err` out 1: result came from an illegal op code.
- `count` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push occurs when `in_valid && in_ready`. The entry is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop occurs when `count != 0 && (!out_valid || out_ready)`. `rd_ptr` increments modulo DEPTH.
- On pop, the output register loads:
  - legal op: `out_data <= sh_data_out`, `out_err <= 0`
  - illegal op: `out_data <= 8'h00`, `out_err <= 1`
  - in both cases `out_op <= head op` and `out_valid <= 1`.
- If there is no pop and `out_valid && out_ready`, then `out_valid <= 0`. `out_data`, `out_op` and `out_err` hold their values.
- `sh_*` are driven combinationally from the head entry when `count != 0`, and are all zero when empty.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged.
- No bypass: when `count == DEPTH`, `in_ready = 0` even if a pop happens in the same cycle.
- Pointers are `clog2(DEPTH)` bits and wrap naturally. Full and empty are decided by `count` only, never by pointer compare.
- `out_data`, `out_op` and `out_err` must stay stable while `out_valid && !out_ready`.
- Commands are never reordered or dropped. Illegal ops still consume one slot and produce one result.

## Timing
- Reset values: `count=0`, both pointers 0, `out_valid=0`, `out_data=0`, `out_op=0`, `out_err=0`, `sh_*=0`, `in_ready=1`. FIFO storage is not reset.
- `rst` asserted mid-operation discards all queued entries and any pending result on that edge. `in_valid` is ignored during the reset cycle.
- Latency: a command accepted at edge k is the FIFO head after k. It is popped at edge k+1, so `out_valid=1` after edge k+1, i.e. 2 edges from acceptance to result.
- Throughput: 1 result per cycle with `out_ready` held high and `in_valid` held high.
- Capacity: with `out_ready=0` and starting empty, DEPTH+1 commands are accepted (1 in the output register, DEPTH in the FIFO). `in_ready` falls after the (DEPTH+1)th accept.
- The shifter path is combinational within one cycle, from `rd_ptr` through the head mux and the shifter into the output register.

## Test plan
1. **Reset values.** Assert `rst` for 2 cycles with `in_valid=1` → `out_valid=0`, `out_data=00000000`, `count=0`, `in_ready=1`, `sh_*=0`, and no push.
2. **Single commands, one per op, `out_ready=1`.** Each result arrives 2 edges after acceptance:
   - LSL 10101010 by 3 → 01010000
   - LSR 11001100 by 2 → 00110011
   - ASR 11110000 by 4 → 11111111
   - ROL 10011001 by 3 → 11001100
   - ROR 01101110 by 2 → 10011011
3. **Backpressure.** Hold `out_ready=0` and push until `in_ready=0` → exactly 5 accepts with DEPTH=4, and `count=4`. `out_data` holds the first result stable. Then release `out_ready=1` → 5 results in order, on consecutive cycles.
4. **Illegal op.** Push data 11111111, amt 1, op 111 between two legal commands → the middle result has `out_err=1`, `out_data=00000000`, `out_op=111`. The neighbouring results are correct with `out_err=0`.
5. **Simultaneous push and pop, plus wrap.** At `count=2`, push and pop in the same cycle → `count` stays 2. Stream 12 commands with random `out_ready` so the pointers wrap 3 times → the output sequence matches a reference model, with no loss or duplication.
6. **Reset mid-stream.** Assert `rst` with 3 entries queued and `out_valid=1` → the next cycle shows `count=0`, `out_valid=0`. A new command afterwards returns its correct result 2 edges after acceptance.
